reservoir_fill_arbiter: RTL and testbench
=========================================

Name: reservoir_fill_arbiter

Overview:
Shares one supply pump/valve manifold between N reservoirs. Each reservoir's level FSM presents flow requests {fr3,fr2,fr1,dfr}.
The block grants the manifold to one reservoir at a time. Selection is by highest demand first, with round-robin tie-break. It enforces a valve changeover dead time and a minimum service dwell, and drives the physical valves for the granted reservoir.

Parameters:
N, 4, number of reservoirs (2..8)
DWELL, 8, minimum SERVE cycles before a voluntary handover (>=1)
GAP, 2, dead-time cycles with all valves closed between grants (>=1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high; clears all state
req_fr  input  3*N  per reservoir i, bits [3i+2:3i] = {fr3,fr2,fr1}
req_dfr  input  N  per reservoir supplemental-flow request
grant  output  N  one-hot granted reservoir; 0 when idle
grant_id  output  clog2(N)  index of granted reservoir; 0 when idle
valve_fr3, valve_fr2, valve_fr1, valve_dfr  output  1 each  manifold valve drives
busy  output  1  high in SWITCH or SERVE

Behaviour:
- Interface: one clock clk; reset is asynchronous and active-high.
- Demand level: lvl(i) = fr3+fr2+fr1 of reservoir i, 2-bit value 0..3. A reservoir is pending if lvl(i) > 0. dfr alone does not make a reservoir pending.
- Selection (combinational):
  - choose the pending reservoir with the maximum lvl;
  - ties go to the first candidate searching upward from (last_served+1) mod N, with wrap-around;
  - current grant_id is excluded when picking a successor in SERVE.
- States: IDLE, SWITCH, SERVE.
  - IDLE: if any reservoir is pending, latch its index to grant_id, load gap_cnt=GAP and go to SWITCH. Otherwise stay.
  - SWITCH: grant asserted, all valves 0. gap_cnt decrements each cycle. When gap_cnt reaches 1, load dwell_cnt=DWELL, set last_served=grant_id and go to SERVE. SWITCH therefore lasts exactly GAP cycles.
  - SERVE: valve_fr3/fr2/fr1/dfr equal the granted reservoir's live req bits (combinational pass-through). dwell_cnt decrements toward 0 and saturates.
- SERVE exits, in priority order:
  - (a) Granted lvl==0: early release. If another reservoir is pending, pick it and go to SWITCH; else go to IDLE.
  - (b) dwell_cnt==0 and another reservoir is pending: pick it and go to SWITCH.
  - (c) dwell_cnt==0, no other pending, granted still pending: stay in SERVE and reload dwell_cnt=DWELL.
  - Otherwise remain in SERVE.
- Outputs:
  - valves are 0 in IDLE and SWITCH;
  - grant/grant_id are 0 in IDLE;
  - busy = (state != IDLE).
- Reset values: state=IDLE, grant=0, grant_id=0, all valves 0, busy=0, gap_cnt=0, dwell_cnt=0, last_served=N-1, so the first search starts at reservoir 0.
- Reset mid-SERVE: valves close asynchronously and immediately. Arbitration restarts from IDLE with last_served=N-1.
- Latency: a pending reservoir seen in IDLE at edge t gives grant at t+1 and valves open at t+1+GAP.
- Requests change during SWITCH: the latched grant is kept. If lvl drops to 0, SERVE is entered and releases on the next edge via rule (a).
- Simultaneous rules (a) and (b): rule (a) wins. Both lead to the same successor selection.

Decomposition:
- Package reservoir_pkg holds:
  - state enum {IDLE, SWITCH, SERVE};
  - demand-level width constant (2);
  - function demand_lvl(fr3,fr2,fr1).
- Sub-module rr_priority_pick holds the combinational max-level round-robin selector.
  - Inputs: lvl vector, last_served, exclude_en, exclude_id.
  - Outputs: found, pick_id.

Test Plan:
- N=4, DWELL=8, GAP=2. Reset, then reservoir 2 raises fr1 at edge 0 -> grant=4'b0100 at edge 1; valves 0 at edges 1-2; valve_fr1=1 from edge 3.
- Reservoirs 0 and 3 pending with lvl 1 and 3 -> reservoir 3 granted first. After 8 SERVE cycles -> 2-cycle gap, then reservoir 0 served.
- Reservoirs 0, 1, 2 all at lvl 2 and held -> service order 0,1,2,0. Each SERVE lasts 8 cycles with 2-cycle gaps.
- Only reservoir 1 pending for 20 cycles -> SERVE held continuously (dwell reloads), grant never drops, no gap inserted.
- Granted reservoir drops to lvl 0 after 3 SERVE cycles with reservoir 3 pending -> SWITCH on the next edge; reservoir 3 valves open 2 cycles later.
- Reset asserted asynchronously mid-SERVE with valve_fr3=1 -> all valves and grant 0 before the next clk edge. After release, reservoir 0 (tied at lvl) wins first.

Source files
------------

// File: rtl/reservoir_pkg.sv
// rtl/reservoir_pkg.sv - shared types and helpers for the reservoir fill arbiter
//
// Purpose : arbiter state encoding, demand-level width and the demand-level
//           helper used to rank reservoir requests.
// Contents: state_t   - IDLE / SWITCH / SERVE
//           LVL_W     - width of a demand level (0..3)
//           demand_lvl(fr3, fr2, fr1) - number of asserted flow requests
package reservoir_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SWITCH = 2'd1,
    SERVE  = 2'd2
  } state_t;

  localparam int LVL_W = 2;

  // Demand level is simply how many of the three flow-request bits are set;
  // the supplemental-flow request deliberately does not contribute.
  function automatic logic [LVL_W-1:0] demand_lvl(input logic fr3,
                                                  input logic fr2,
                                                  input logic fr1);
    return {1'b0, fr3} + {1'b0, fr2} + {1'b0, fr1};
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// rtl/rr_priority_pick.sv - combinational max-level selector with round-robin tie-break
//
// Purpose : picks the reservoir with the highest non-zero demand level; among
//           equal levels the first one found searching upward from
//           last_served+1 (wrapping) wins. One reservoir may be excluded.
// Ports   : lvl         in  N*LVL_W  packed demand levels, reservoir i at [i*LVL_W +: LVL_W]
//           last_served in  ID_W     search starts just after this index
//           exclude_en  in  1        enable exclusion of exclude_id
//           exclude_id  in  ID_W     reservoir that may not be picked
//           found       out 1        some eligible reservoir has level > 0
//           pick_id     out ID_W     chosen reservoir (0 when not found)
module rr_priority_pick
  import reservoir_pkg::*;
#(
  parameter  int N    = 4,
  localparam int ID_W = $clog2(N)
) (
  input  logic [N*LVL_W-1:0] lvl,
  input  logic [ID_W-1:0]    last_served,
  input  logic               exclude_en,
  input  logic [ID_W-1:0]    exclude_id,
  output logic               found,
  output logic [ID_W-1:0]    pick_id
);

  logic [LVL_W-1:0] best_lvl;
  int               idx;

  // Walking the candidates in round-robin order and only replacing the
  // current best on a strictly greater level makes the earliest candidate
  // win any tie.
  always_comb begin
    found    = 1'b0;
    pick_id  = '0;
    best_lvl = '0;
    idx      = 0;
    for (int k = 1; k <= N; k++) begin
      idx = int'(last_served) + k;
      if (idx >= N) begin
        idx = idx - N;
      end
      if (!(exclude_en && (idx == int'(exclude_id))) &&
          (lvl[idx*LVL_W +: LVL_W] > best_lvl)) begin
        found    = 1'b1;
        pick_id  = ID_W'(idx);
        best_lvl = lvl[idx*LVL_W +: LVL_W];
      end
    end
  end

endmodule

// File: rtl/reservoir_fill_arbiter.sv
// rtl/reservoir_fill_arbiter.sv - grants a shared pump/valve manifold to one reservoir at a time
//
// Purpose : highest-demand-first arbitration with round-robin tie-break,
//           a valve changeover dead time (GAP cycles, all valves closed) and a
//           minimum service dwell (DWELL) before a voluntary handover.
// Ports   : clk        in  1        rising-edge clock
//           reset      in  1        asynchronous active-high reset
//           req_fr     in  3*N      {fr3,fr2,fr1} of reservoir i at [3i+2:3i]
//           req_dfr    in  N        supplemental-flow request per reservoir
//           grant      out N        one-hot granted reservoir, 0 when idle
//           grant_id   out ID_W     index of granted reservoir, 0 when idle
//           valve_fr3/fr2/fr1/dfr  out 1 each  manifold valve drives
//           busy       out 1        high while switching or serving
module reservoir_fill_arbiter
  import reservoir_pkg::*;
#(
  parameter  int N     = 4,
  parameter  int DWELL = 8,
  parameter  int GAP   = 2,
  localparam int ID_W  = $clog2(N)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3*N-1:0]    req_fr,
  input  logic [N-1:0]      req_dfr,
  output logic [N-1:0]      grant,
  output logic [ID_W-1:0]   grant_id,
  output logic              valve_fr3,
  output logic              valve_fr2,
  output logic              valve_fr1,
  output logic              valve_dfr,
  output logic              busy
);

  localparam int GAP_W   = $clog2(GAP + 1);
  localparam int DWELL_W = $clog2(DWELL + 1);

  localparam logic [GAP_W-1:0]   GAP_V     = GAP_W'(GAP);
  localparam logic [GAP_W-1:0]   GAP_ONE   = GAP_W'(1);
  localparam logic [DWELL_W-1:0] DWELL_V   = DWELL_W'(DWELL);
  localparam logic [DWELL_W-1:0] DWELL_ONE = DWELL_W'(1);
  localparam logic [ID_W-1:0]    LAST_RST  = ID_W'(N - 1);
  localparam logic [N-1:0]       GRANT0    = N'(1);

  state_t             state, state_n;
  logic [ID_W-1:0]    gid_q, gid_n;
  logic [GAP_W-1:0]   gap_cnt, gap_n;
  logic [DWELL_W-1:0] dwell_cnt, dwell_n;
  logic [ID_W-1:0]    last_served, last_n;

  logic [N*LVL_W-1:0] lvl;
  logic [LVL_W-1:0]   granted_lvl;
  logic               found;
  logic [ID_W-1:0]    pick_id;
  logic               serving;

  always_comb begin
    lvl = '0;
    for (int i = 0; i < N; i++) begin
      lvl[i*LVL_W +: LVL_W] = demand_lvl(req_fr[3*i+2], req_fr[3*i+1], req_fr[3*i]);
    end
  end

  assign granted_lvl = lvl[int'(gid_q)*LVL_W +: LVL_W];

  // While serving, last_served equals the current grant, so the successor
  // search naturally starts just after it; the grant itself is excluded.
  rr_priority_pick #(.N(N)) u_pick (
    .lvl         (lvl),
    .last_served (last_served),
    .exclude_en  (state == SERVE),
    .exclude_id  (gid_q),
    .found       (found),
    .pick_id     (pick_id)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      gid_q       <= '0;
      gap_cnt     <= '0;
      dwell_cnt   <= '0;
      last_served <= LAST_RST;
    end else begin
      state       <= state_n;
      gid_q       <= gid_n;
      gap_cnt     <= gap_n;
      dwell_cnt   <= dwell_n;
      last_served <= last_n;
    end
  end

  always_comb begin
    state_n = state;
    gid_n   = gid_q;
    gap_n   = gap_cnt;
    dwell_n = dwell_cnt;
    last_n  = last_served;
    case (state)
      IDLE: begin
        if (found) begin
          gid_n   = pick_id;
          gap_n   = GAP_V;
          state_n = SWITCH;
        end
      end
      SWITCH: begin
        if (gap_cnt != '0) begin
          gap_n = gap_cnt - GAP_ONE;
        end
        // Leaving on the count of 1 makes the dead time exactly GAP cycles.
        if (gap_cnt <= GAP_ONE) begin
          dwell_n = DWELL_V;
          last_n  = gid_q;
          state_n = SERVE;
        end
      end
      SERVE: begin
        if (granted_lvl == '0) begin
          // Granted reservoir no longer needs water: release without waiting
          // for the dwell to expire.
          if (found) begin
            gid_n   = pick_id;
            gap_n   = GAP_V;
            state_n = SWITCH;
          end else begin
            gid_n   = '0;
            state_n = IDLE;
          end
        end else if (dwell_cnt == '0) begin
          if (found) begin
            gid_n   = pick_id;
            gap_n   = GAP_V;
            state_n = SWITCH;
          end else begin
            // Nobody else waiting: keep the valves open, no gap.
            dwell_n = DWELL_V;
          end
        end else begin
          dwell_n = dwell_cnt - DWELL_ONE;
        end
      end
      default: begin
        state_n = IDLE;
        gid_n   = '0;
      end
    endcase
  end

  // Valves follow the live request bits so they react within the cycle,
  // and close the instant reset pulls the state back to IDLE.
  assign serving   = (state == SERVE);
  assign busy      = (state != IDLE);
  assign grant_id  = busy ? gid_q : '0;
  assign grant     = busy ? (GRANT0 << gid_q) : '0;
  assign valve_fr3 = serving & req_fr[3*int'(gid_q)+2];
  assign valve_fr2 = serving & req_fr[3*int'(gid_q)+1];
  assign valve_fr1 = serving & req_fr[3*int'(gid_q)];
  assign valve_dfr = serving & req_dfr[gid_q];

endmodule

// File: tb/tb_reservoir_fill_arbiter.sv
// tb/tb_reservoir_fill_arbiter.sv - self-checking bench for reservoir_fill_arbiter
module tb_reservoir_fill_arbiter;

  localparam int N     = 4;
  localparam int DWELL = 8;
  localparam int GAP   = 2;
  localparam int ID_W  = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic [3*N-1:0]   req_fr;
  logic [N-1:0]     req_dfr;
  logic [N-1:0]     grant;
  logic [ID_W-1:0]  grant_id;
  logic             valve_fr3, valve_fr2, valve_fr1, valve_dfr;
  logic             busy;

  reservoir_fill_arbiter #(.N(N), .DWELL(DWELL), .GAP(GAP)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_fr    (req_fr),
    .req_dfr   (req_dfr),
    .grant     (grant),
    .grant_id  (grant_id),
    .valve_fr3 (valve_fr3),
    .valve_fr2 (valve_fr2),
    .valve_fr1 (valve_fr1),
    .valve_dfr (valve_dfr),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: who owns the manifold and how long it has been there.
  int m_owner;
  int m_last;
  bit m_in_sw;
  int m_sw_age;
  int m_age;

  int  gnt_log[$];
  bit  prev_busy;
  int  prev_gid;

  typedef struct {
    logic [3*N-1:0] fr;
    logic [N-1:0]   dfr;
    logic [N-1:0]   g;
    logic [ID_W-1:0] gid;
    logic [3:0]     v;
    logic           b;
  } vec_t;

  vec_t tbl[8];
  vec_t cur_vec;
  bit   tbl_en = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int lvl_of(input logic [3*N-1:0] fr, input int i);
    return int'(fr[3*i]) + int'(fr[3*i+1]) + int'(fr[3*i+2]);
  endfunction

  // Highest level first, then the earliest such reservoir after 'last'.
  function automatic int model_pick(input logic [3*N-1:0] fr, input int last, input int excl);
    int mx = 0;
    for (int i = 0; i < N; i++)
      if (i != excl && lvl_of(fr, i) > mx) mx = lvl_of(fr, i);
    if (mx == 0) return -1;
    for (int k = 1; k <= N; k++) begin
      int i = (last + k) % N;
      if (i != excl && lvl_of(fr, i) == mx) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner  = -1;
    m_last   = N - 1;
    m_in_sw  = 0;
    m_sw_age = 0;
    m_age    = 0;
  endtask

  task automatic start_switch(input int p);
    m_owner  = p;
    m_in_sw  = 1;
    m_sw_age = 0;
  endtask

  task automatic model_update(input logic [3*N-1:0] fr);
    int p;
    if (m_owner < 0) begin
      p = model_pick(fr, m_last, -1);
      if (p >= 0) start_switch(p);
    end else if (m_in_sw) begin
      m_sw_age++;
      if (m_sw_age == GAP) begin
        m_in_sw = 0;
        m_last  = m_owner;
        m_age   = 0;
      end
    end else begin
      p = model_pick(fr, m_owner, m_owner);
      if (lvl_of(fr, m_owner) == 0) begin
        if (p >= 0) start_switch(p);
        else m_owner = -1;
      end else if (m_age >= DWELL) begin
        if (p >= 0) start_switch(p);
        else m_age = 0;
      end else begin
        m_age++;
      end
    end
  endtask

  task automatic check_outputs();
    logic [N-1:0] eg;
    logic [3:0]   ev;
    int           eid;
    eg  = '0;
    ev  = '0;
    eid = 0;
    if (m_owner >= 0) begin
      eg  = N'(1 << m_owner);
      eid = m_owner;
      if (!m_in_sw)
        ev = {req_fr[3*m_owner+2], req_fr[3*m_owner+1], req_fr[3*m_owner], req_dfr[m_owner]};
    end
    chk("model_grant", grant, eg);
    chk("model_grant_id", grant_id, eid);
    chk("model_busy", busy, m_owner >= 0);
    chk("model_valves", {valve_fr3, valve_fr2, valve_fr1, valve_dfr}, ev);
    if (tbl_en) begin
      chk("tbl_grant", grant, cur_vec.g);
      chk("tbl_grant_id", grant_id, cur_vec.gid);
      chk("tbl_valves", {valve_fr3, valve_fr2, valve_fr1, valve_dfr}, cur_vec.v);
      chk("tbl_busy", busy, cur_vec.b);
    end
  endtask

  // One clock: drive inputs, check at the falling edge, advance the model
  // with the inputs the DUT samples at the rising edge.
  task automatic step(input logic [3*N-1:0] fr, input logic [N-1:0] dfr);
    req_fr  = fr;
    req_dfr = dfr;
    @(negedge clk);
    check_outputs();
    if (busy && (!prev_busy || int'(grant_id) != prev_gid))
      gnt_log.push_back(int'(grant_id));
    prev_busy = busy;
    prev_gid  = int'(grant_id);
    @(posedge clk);
    model_update(fr);
    #1;
  endtask

  task automatic clear_log();
    gnt_log.delete();
    prev_busy = 0;
    prev_gid  = 0;
  endtask

  task automatic check_log(input string nm, input int n, input int a, input int b,
                           input int c, input int d);
    int ex[4];
    ex = '{a, b, c, d};
    chk({nm, "_len"}, gnt_log.size(), n);
    for (int i = 0; i < n && i < gnt_log.size(); i++)
      chk({nm, "_id"}, gnt_log[i], ex[i]);
  endtask

  task automatic apply_reset();
    reset   = 1'b1;
    req_fr  = '0;
    req_dfr = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    clear_log();
  endtask

  initial begin
    tbl[0] = '{fr: 12'h040, dfr: 4'b0000, g: 4'b0000, gid: 2'd0, v: 4'b0000, b: 1'b0};
    tbl[1] = '{fr: 12'h040, dfr: 4'b0000, g: 4'b0100, gid: 2'd2, v: 4'b0000, b: 1'b1};
    tbl[2] = '{fr: 12'h040, dfr: 4'b0000, g: 4'b0100, gid: 2'd2, v: 4'b0000, b: 1'b1};
    tbl[3] = '{fr: 12'h040, dfr: 4'b0000, g: 4'b0100, gid: 2'd2, v: 4'b0010, b: 1'b1};
    tbl[4] = '{fr: 12'h040, dfr: 4'b0100, g: 4'b0100, gid: 2'd2, v: 4'b0011, b: 1'b1};
    tbl[5] = '{fr: 12'h000, dfr: 4'b0000, g: 4'b0100, gid: 2'd2, v: 4'b0000, b: 1'b1};
    tbl[6] = '{fr: 12'h000, dfr: 4'b0010, g: 4'b0000, gid: 2'd0, v: 4'b0000, b: 1'b0};
    tbl[7] = '{fr: 12'h000, dfr: 4'b0010, g: 4'b0000, gid: 2'd0, v: 4'b0000, b: 1'b0};

    reset   = 1'b1;
    req_fr  = '0;
    req_dfr = '0;
    apply_reset();
    chk("reset_grant", grant, 0);
    chk("reset_grant_id", grant_id, 0);
    chk("reset_busy", busy, 0);
    chk("reset_valves", {valve_fr3, valve_fr2, valve_fr1, valve_dfr}, 0);

    // Single request latency, dfr pass-through, early release to idle.
    tbl_en = 1;
    for (int i = 0; i < 8; i++) begin
      cur_vec = tbl[i];
      step(tbl[i].fr, tbl[i].dfr);
    end
    tbl_en = 0;

    // Level 3 on reservoir 3 beats level 1 on reservoir 0; 0 follows after dwell.
    apply_reset();
    for (int i = 0; i < 20; i++) step(12'hE01, 4'b0000);
    check_log("prio_order", 2, 3, 0, 0, 0);

    // Three reservoirs tied at level 2 rotate 0,1,2,0.
    apply_reset();
    for (int i = 0; i < 40; i++) step(12'h0DB, 4'b0000);
    check_log("rr_order", 4, 0, 1, 2, 0);

    // Lone requester keeps the manifold through dwell reloads.
    apply_reset();
    for (int i = 0; i < 25; i++) step(12'h008, 4'b0000);
    check_log("hold", 1, 1, 0, 0, 0);
    chk("hold_grant", grant, 4'b0010);
    chk("hold_valve_fr1", valve_fr1, 1);

    // Early release after three serve cycles hands over to reservoir 3.
    apply_reset();
    for (int i = 0; i < 6; i++) step(12'h218, 4'b0000);
    step(12'h200, 4'b0000);
    chk("release_grant", grant, 4'b1000);
    chk("release_valves", {valve_fr3, valve_fr2, valve_fr1, valve_dfr}, 0);
    step(12'h200, 4'b0000);
    step(12'h200, 4'b1000);
    chk("release_open_fr1", valve_fr1, 1);
    chk("release_open_dfr", valve_dfr, 1);

    // Asynchronous reset while reservoir 1 is being served with fr3.
    apply_reset();
    for (int i = 0; i < 5; i++) step(12'h020, 4'b0000);
    chk("pre_reset_fr3", valve_fr3, 1);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    chk("async_valves", {valve_fr3, valve_fr2, valve_fr1, valve_dfr}, 0);
    chk("async_grant", grant, 0);
    chk("async_busy", busy, 0);
    req_fr = '0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    clear_log();
    for (int i = 0; i < 3; i++) step(12'h249, 4'b0000);
    check_log("after_reset", 1, 0, 0, 0, 0);

    // Randomized traffic against the reference model.
    apply_reset();
    begin
      logic [3*N-1:0] fr;
      logic [N-1:0]   dfr;
      fr  = '0;
      dfr = '0;
      for (int c = 0; c < 800; c++) begin
        if ($urandom_range(0, 4) == 0) begin
          for (int r = 0; r < N; r++)
            fr[3*r +: 3] = ($urandom_range(0, 2) == 0) ? 3'b000 : 3'($urandom);
          dfr = N'($urandom);
        end
        step(fr, dfr);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
